tb_response_checker: RTL and testbench

- Receiving end of the stimulus/log flow used in the benchmark trojan-detection benches.
- Accepts (applied vector, sampled DUT output) pairs through a valid/ready handshake.
- Compares each pair against a golden truth table loaded beforehand, tracks exhaustive vector coverage and counts mismatches.
- Raises done/pass in hardware, replacing the text-file log diff.

---
 rtl/tb_response_checker.sv | 198 +++++++++++++++++++
 tb/tb_tb_response_checker.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_response_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_response_checker
// Brief    : Hardware response checker for trojan-detection benches. Accepts
//            (applied vector, observed response) pairs over valid/ready,
//            compares each against a preloaded golden truth table, tracks
//            exhaustive vector coverage, counts mismatches and raises
//            done/pass at the end of a run.
// Options  : RESP_SIGNATURE_EN - adds a 16-bit MISR signature output
//            (x^16+x^12+x^5+1) folded over every accepted pair.
// Revision : 1.0 - initial release
// ============================================================================
module tb_response_checker #(
    parameter int N_IN    = 2,
    parameter int N_OUT   = 1,
    parameter int MAX_ERR = 3
) (
    input  logic                  CK,
    input  logic                  reset,
    input  logic                  golden_we,
    input  logic [N_IN-1:0]       golden_addr,
    input  logic [N_OUT-1:0]      golden_data,
    input  logic                  start,
    input  logic                  vec_valid,
    output logic                  vec_ready,
    input  logic [N_IN-1:0]       vec_in,
    input  logic [N_OUT-1:0]      resp_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_IN:0]         mismatch_count,
    output logic                  first_fail_valid,
    output logic [N_IN-1:0]       first_fail_vec,
    output logic [(2**N_IN)-1:0]  coverage
`ifdef RESP_SIGNATURE_EN
    ,
    output logic [15:0]           signature
`endif
);

    localparam int              c_depth   = 2**N_IN;
    localparam logic [N_IN:0]   c_cnt_max = '1;
    localparam logic [N_IN:0]   c_max_err = (N_IN+1)'(MAX_ERR);

    localparam logic [1:0]      c_st_idle  = 2'd0;
    localparam logic [1:0]      c_st_run   = 2'd1;
    localparam logic [1:0]      c_st_drain = 2'd2;
    localparam logic [1:0]      c_st_done  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;

    logic [N_OUT-1:0]    r_golden [c_depth];

    logic                r_pipe_valid;
    logic [N_IN-1:0]     r_pipe_vec;
    logic [N_OUT-1:0]    r_pipe_resp;

    logic [N_IN:0]       r_mismatch_count;
    logic                r_first_fail_valid;
    logic [N_IN-1:0]     r_first_fail_vec;
    logic [c_depth-1:0]  r_coverage;

    logic                w_start;
    logic                w_golden_wr;
    logic                w_accept;
    logic [N_OUT-1:0]    w_expected;
    logic                w_mismatch;
    logic [c_depth-1:0]  w_cov_hit;
    logic [c_depth-1:0]  w_cov_next;
    logic [N_IN:0]       w_cnt_next;
    logic                w_finish;

    // A run may be (re)started only from IDLE or DONE; mid-run start is ignored.
    assign w_start     = start & ((r_state == c_st_idle) | (r_state == c_st_done));
    assign w_golden_wr = golden_we & (r_state == c_st_idle);

    // The compare stage works on the registered pair; post-update values
    // decide whether this compare ends the run.
    assign w_expected  = r_golden[r_pipe_vec];
    assign w_mismatch  = r_pipe_valid & (r_pipe_resp != w_expected);
    assign w_cov_hit   = {{(c_depth-1){1'b0}}, 1'b1} << r_pipe_vec;
    assign w_cov_next  = r_pipe_valid ? (r_coverage | w_cov_hit) : r_coverage;
    assign w_cnt_next  = (w_mismatch && (r_mismatch_count != c_cnt_max))
                         ? r_mismatch_count + 1'b1 : r_mismatch_count;
    assign w_finish    = r_pipe_valid & ((&w_cov_next) | (w_cnt_next >= c_max_err));

    // Ready is withdrawn already in the terminating compare cycle so that no
    // pair slips in behind the one that ends the run.
    assign vec_ready   = (r_state == c_st_run) & ~w_finish;
    assign w_accept    = vec_valid & vec_ready;

    assign busy             = (r_state == c_st_run) | (r_state == c_st_drain);
    assign done             = (r_state == c_st_done);
    assign pass             = done & (r_mismatch_count == '0) & (&r_coverage);
    assign mismatch_count   = r_mismatch_count;
    assign first_fail_valid = r_first_fail_valid;
    assign first_fail_vec   = r_first_fail_vec;
    assign coverage         = r_coverage;

    // State register.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: RUN ends on full coverage or error threshold, DRAIN
    // retires the compare stage, DONE holds results until the next start.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (w_start)  w_state_next = c_st_run;
            c_st_run:   if (w_finish) w_state_next = c_st_drain;
            c_st_drain:               w_state_next = c_st_done;
            c_st_done:  if (w_start)  w_state_next = c_st_run;
            default:                  w_state_next = c_st_idle;
        endcase
    end

    // Golden truth table: cleared by reset, writable only while IDLE.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_golden[i] <= '0;
            end
        end else if (w_golden_wr) begin
            r_golden[golden_addr] <= golden_data;
        end
    end

    // One-stage compare pipeline holding the last accepted pair.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_pipe_valid <= 1'b0;
            r_pipe_vec   <= '0;
            r_pipe_resp  <= '0;
        end else if (w_start) begin
            r_pipe_valid <= 1'b0;
        end else begin
            r_pipe_valid <= w_accept;
            if (w_accept) begin
                r_pipe_vec  <= vec_in;
                r_pipe_resp <= resp_in;
            end
        end
    end

    // Result bookkeeping: coverage, saturating mismatch count, first failure.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_coverage         <= '0;
            r_mismatch_count   <= '0;
            r_first_fail_valid <= 1'b0;
            r_first_fail_vec   <= '0;
        end else if (w_start) begin
            r_coverage         <= '0;
            r_mismatch_count   <= '0;
            r_first_fail_valid <= 1'b0;
            r_first_fail_vec   <= '0;
        end else begin
            r_coverage       <= w_cov_next;
            r_mismatch_count <= w_cnt_next;
            if (w_mismatch && !r_first_fail_valid) begin
                r_first_fail_valid <= 1'b1;
                r_first_fail_vec   <= r_pipe_vec;
            end
        end
    end

`ifdef RESP_SIGNATURE_EN
    logic [15:0] r_signature;
    logic [15:0] w_sig_data;
    logic [15:0] w_sig_next;

    assign w_sig_data = 16'({r_pipe_vec, r_pipe_resp});
    assign w_sig_next = {r_signature[14:0], 1'b0}
                        ^ (r_signature[15] ? 16'h1021 : 16'h0000)
                        ^ w_sig_data;
    assign signature  = r_signature;

    // MISR over accepted pairs, seeded at start; no compares occur in DONE so
    // the value stays frozen there.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_signature <= 16'h0000;
        end else if (w_start) begin
            r_signature <= 16'hFFFF;
        end else if (r_pipe_valid) begin
            r_signature <= w_sig_next;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tb_response_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_tb_response_checker
// Brief    : Directed self-checking bench for tb_response_checker. Linear
//            sequence of directed steps with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tb_response_checker;

    logic        CK = 1'b0;
    logic        reset = 1'b0;
    logic        golden_we = 1'b0;
    logic [1:0]  golden_addr = '0;
    logic [0:0]  golden_data = '0;
    logic        start = 1'b0;
    logic        vec_valid = 1'b0;
    logic        vec_ready;
    logic [1:0]  vec_in = '0;
    logic [0:0]  resp_in = '0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [2:0]  mismatch_count;
    logic        first_fail_valid;
    logic [1:0]  first_fail_vec;
    logic [3:0]  coverage;
`ifdef RESP_SIGNATURE_EN
    logic [15:0] signature;
    logic [15:0] sig_first;
`endif

    int n_checks = 0;
    int n_errors = 0;

    tb_response_checker #(.N_IN(2), .N_OUT(1), .MAX_ERR(3)) dut (
        .CK               (CK),
        .reset            (reset),
        .golden_we        (golden_we),
        .golden_addr      (golden_addr),
        .golden_data      (golden_data),
        .start            (start),
        .vec_valid        (vec_valid),
        .vec_ready        (vec_ready),
        .vec_in           (vec_in),
        .resp_in          (resp_in),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .mismatch_count   (mismatch_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec),
        .coverage         (coverage)
`ifdef RESP_SIGNATURE_EN
        ,
        .signature        (signature)
`endif
    );

    // Free-running clock, 10 time-unit period.
    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 unit past the edge.
    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Present a pair until a handshake occurs (bounded).
    task automatic send_pair(input logic [1:0] v, input logic r);
        logic got;
        got       = 1'b0;
        vec_valid = 1'b1;
        vec_in    = v;
        resp_in   = r;
        for (int i = 0; i < 20 && !got; i++) begin
            got = vec_ready;
            tick();
        end
        vec_valid = 1'b0;
        check("handshake", {31'd0, got}, 32'd1);
    endtask

    // Load the AND truth table.
    task automatic load_and();
        for (int i = 0; i < 4; i++) begin
            golden_we   = 1'b1;
            golden_addr = 2'(i);
            golden_data = (i == 3) ? 1'b1 : 1'b0;
            tick();
        end
        golden_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ready"}, {31'd0, vec_ready}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy},      32'd0);
        check({tag, "_done"},  {31'd0, done},      32'd0);
        check({tag, "_pass"},  {31'd0, pass},      32'd0);
        check({tag, "_cnt"},   {29'd0, mismatch_count}, 32'd0);
        check({tag, "_ffv"},   {31'd0, first_fail_valid}, 32'd0);
        check({tag, "_ffvec"}, {30'd0, first_fail_vec},   32'd0);
        check({tag, "_cov"},   {28'd0, coverage},  32'd0);
    endtask

`ifdef RESP_SIGNATURE_EN
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
        logic fb;
        fb = s[15];
        s  = s << 1;
        if (fb) s = s ^ 16'h1021;
        return s ^ d;
    endfunction

    function automatic logic [15:0] sig_and_run();
        logic [15:0] s;
        s = 16'hFFFF;
        s = misr_step(s, 16'h0000);   // 00/0
        s = misr_step(s, 16'h0002);   // 01/0
        s = misr_step(s, 16'h0004);   // 10/0
        s = misr_step(s, 16'h0007);   // 11/1
        return s;
    endfunction
`endif

    initial begin
        // Reset state
        #3;
        check_idle_zero("rst");
        @(posedge CK); #1;
        reset = 1'b1;
        tick();
        check_idle_zero("idle");

        // Scenario 1: clean AND run
        load_and();
        do_start();
        check("s1_busy",  {31'd0, busy},      32'd1);
        check("s1_ready", {31'd0, vec_ready}, 32'd1);
        send_pair(2'b00, 1'b0);
        send_pair(2'b01, 1'b0);
        send_pair(2'b10, 1'b0);
        send_pair(2'b11, 1'b1);
        check("s1_ready_drop", {31'd0, vec_ready}, 32'd0);
        check("s1_done_early", {31'd0, done},      32'd0);
        tick();
        check("s1_drain_busy", {31'd0, busy}, 32'd1);
        check("s1_drain_done", {31'd0, done}, 32'd0);
        tick();
        check("s1_done", {31'd0, done}, 32'd1);
        check("s1_busy_off", {31'd0, busy}, 32'd0);
        check("s1_pass", {31'd0, pass}, 32'd1);
        check("s1_cnt", {29'd0, mismatch_count}, 32'd0);
        check("s1_cov", {28'd0, coverage}, 32'hF);
`ifdef RESP_SIGNATURE_EN
        check("s1_sig", {16'd0, signature}, {16'd0, sig_and_run()});
        sig_first = signature;
`endif

        // Golden write in DONE must be ignored (would make 11/0 a match)
        golden_we   = 1'b1;
        golden_addr = 2'b11;
        golden_data = 1'b0;
        tick();
        golden_we = 1'b0;
        check("done_hold", {31'd0, done}, 32'd1);

        // Scenario 2: one early mismatch
        do_start();
        check("s2_clr_cnt", {29'd0, mismatch_count}, 32'd0);
        check("s2_clr_cov", {28'd0, coverage}, 32'd0);
        check("s2_clr_done", {31'd0, done}, 32'd0);
        send_pair(2'b11, 1'b0);
        send_pair(2'b00, 1'b0);
        send_pair(2'b01, 1'b0);
        send_pair(2'b10, 1'b0);
        tick();
        tick();
        check("s2_done", {31'd0, done}, 32'd1);
        check("s2_pass", {31'd0, pass}, 32'd0);
        check("s2_cnt", {29'd0, mismatch_count}, 32'd1);
        check("s2_ffv", {31'd0, first_fail_valid}, 32'd1);
        check("s2_ffvec", {30'd0, first_fail_vec}, 32'd3);
        check("s2_cov", {28'd0, coverage}, 32'hF);

        // Scenario 3: error threshold abort
        do_start();
        send_pair(2'b00, 1'b1);
        send_pair(2'b01, 1'b1);
        send_pair(2'b10, 1'b1);
        check("s3_ready_drop", {31'd0, vec_ready}, 32'd0);
        vec_valid = 1'b1;
        vec_in    = 2'b11;
        resp_in   = 1'b1;
        tick();
        check("s3_drain_ready", {31'd0, vec_ready}, 32'd0);
        tick();
        vec_valid = 1'b0;
        check("s3_done", {31'd0, done}, 32'd1);
        check("s3_cov", {28'd0, coverage}, 32'h7);
        check("s3_cnt", {29'd0, mismatch_count}, 32'd3);
        check("s3_pass", {31'd0, pass}, 32'd0);
        check("s3_ffvec", {30'd0, first_fail_vec}, 32'd0);
        tick();
        check("s3_cov_hold", {28'd0, coverage}, 32'h7);

        // Scenario 4: duplicate vector, completion only after 11
        do_start();
        send_pair(2'b01, 1'b0);
        send_pair(2'b01, 1'b0);
        send_pair(2'b00, 1'b0);
        send_pair(2'b10, 1'b0);
        tick();
        tick();
        check("s4_cov_partial", {28'd0, coverage}, 32'h7);
        check("s4_not_done", {31'd0, done}, 32'd0);
        check("s4_busy", {31'd0, busy}, 32'd1);
        check("s4_ready", {31'd0, vec_ready}, 32'd1);
        send_pair(2'b11, 1'b1);
        tick();
        tick();
        check("s4_done", {31'd0, done}, 32'd1);
        check("s4_pass", {31'd0, pass}, 32'd1);
        check("s4_cnt", {29'd0, mismatch_count}, 32'd0);

        // Scenario 5: asynchronous reset mid-run, then clean rerun
        do_start();
        send_pair(2'b00, 1'b1);
        send_pair(2'b01, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_idle_zero("s5_async");
        #2;
        reset = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            golden_we   = 1'b1;
            golden_addr = 2'(i);
            golden_data = 1'b0;
            tick();
        end
        golden_we   = 1'b1;
        golden_addr = 2'b11;
        golden_data = 1'b1;
        start       = 1'b1;
        tick();
        golden_we = 1'b0;
        start     = 1'b0;
        check("s5_busy", {31'd0, busy}, 32'd1);
        send_pair(2'b00, 1'b0);
        send_pair(2'b01, 1'b0);
        send_pair(2'b10, 1'b0);
        send_pair(2'b11, 1'b1);
        tick();
        tick();
        check("s5_done", {31'd0, done}, 32'd1);
        check("s5_pass", {31'd0, pass}, 32'd1);
        check("s5_cnt", {29'd0, mismatch_count}, 32'd0);

`ifdef RESP_SIGNATURE_EN
        check("s5_sig", {16'd0, signature}, {16'd0, sig_and_run()});
        do_start();
        check("sig_seed", {16'd0, signature}, 32'h0000FFFF);
        send_pair(2'b00, 1'b0);
        send_pair(2'b01, 1'b0);
        send_pair(2'b10, 1'b0);
        send_pair(2'b11, 1'b1);
        tick();
        tick();
        check("sig_repeat", {16'd0, signature}, {16'd0, sig_first});
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
